// File: rtl/pipe_stage_skid.sv
// Payload-agnostic pipeline stage register with a valid/ready handshake, an optional
// 2-entry skid buffer, flush-to-bubble and a saturating bubble-cycle counter.
`timescale 1ns/1ps
module pipe_stage_skid #(
    parameter int                   PAYLOAD_W = 145,
    parameter logic [PAYLOAD_W-1:0] BUBBLE    = '0,
    parameter int                   SKID_EN   = 1,
    parameter int                   STALL_W   = 6,
    parameter int                   STALL_BIT = 2,
    parameter int                   CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occupancy,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     bubble_cnt
);

    // Handshake: a beat crosses a boundary at the posedge where valid and ready are
    // both high. valid never waits on ready; a producer holds data while valid&~ready.
    // Downstream transfer is additionally blocked by this stage's stall bit.

    logic                 main_v, skid_v;
    logic                 main_v_n, skid_v_n;
    logic [PAYLOAD_W-1:0] main_d, skid_d;
    logic [PAYLOAD_W-1:0] main_d_n, skid_d_n;
    logic                 rdy_q;
    logic [1:0]           occ_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 in_fire;
    logic                 out_fire;
    logic                 stall_unused;

    assign stall_unused = ^stall;

    assign out_fire = main_v & out_ready & ~stall[STALL_BIT];

    // With the skid, ready is a flop (no comb path from out_ready); without it,
    // a full main slot can still accept when it drains in the same cycle.
    assign in_ready = (SKID_EN != 0) ? rdy_q : (rst & (~main_v | out_fire));
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        main_v_n = main_v;
        skid_v_n = skid_v;
        main_d_n = main_d;
        skid_d_n = skid_d;
        if (flush) begin
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
            main_d_n = BUBBLE;
            skid_d_n = BUBBLE;
        end else if (SKID_EN == 0) begin
            if (in_fire) begin
                main_v_n = 1'b1;
                main_d_n = in_data;
            end else if (out_fire) begin
                main_v_n = 1'b0;
                main_d_n = BUBBLE;
            end
        end else if (!main_v) begin
            if (in_fire) begin
                main_v_n = 1'b1;
                main_d_n = in_data;
            end
        end else if (out_fire) begin
            if (skid_v) begin
                // skid full implies in_ready was low, so no new beat this cycle
                main_d_n = skid_d;
                skid_v_n = 1'b0;
                skid_d_n = BUBBLE;
            end else if (in_fire) begin
                main_d_n = in_data;
            end else begin
                main_v_n = 1'b0;
                main_d_n = BUBBLE;
            end
        end else if (in_fire) begin
            skid_v_n = 1'b1;
            skid_d_n = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= BUBBLE;
            skid_d <= BUBBLE;
            rdy_q  <= 1'b0;
            occ_q  <= 2'd0;
            cnt_q  <= '0;
        end else begin
            main_v <= main_v_n;
            skid_v <= skid_v_n;
            main_d <= main_d_n;
            skid_d <= skid_d_n;
            rdy_q  <= ~skid_v_n;
            occ_q  <= {1'b0, main_v_n} + {1'b0, skid_v_n};
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (!main_v && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_valid  = main_v;
    assign out_data   = main_d;
    assign occupancy  = occ_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: one skid instance (CNT_W=4) and one single-entry instance,
// exercised one at a time through a shared stimulus/observation mux.
`timescale 1ns/1ps
module tb_pipe_stage_skid;

    localparam int            PW  = 145;
    localparam int            SW  = 6;
    localparam int            SB  = 2;
    localparam logic [PW-1:0] BUB = '0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          flush;
    logic          cnt_clr;
    logic          in_valid;
    logic          out_ready;
    logic          sel_ns;
    logic [SW-1:0] stall;
    logic [PW-1:0] in_data;

    logic          sk_in_ready, sk_out_valid;
    logic [PW-1:0] sk_out_data;
    logic [1:0]    sk_occ;
    logic [3:0]    sk_cnt;
    logic          ns_in_ready, ns_out_valid;
    logic [PW-1:0] ns_out_data;
    logic [1:0]    ns_occ;
    logic [15:0]   ns_cnt;

    logic          o_in_ready, o_out_valid;
    logic [PW-1:0] o_out_data;
    logic [1:0]    o_occ;
    logic [15:0]   o_cnt;

    int vectors = 0;
    int miscompares = 0;
    logic mon_en = 1'b0;
    logic [PW-1:0] exp_q[$];

    pipe_stage_skid #(.PAYLOAD_W(PW), .SKID_EN(1), .STALL_W(SW), .STALL_BIT(SB), .CNT_W(4)) u_skid (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid & ~sel_ns), .in_ready(sk_in_ready), .in_data(in_data),
        .out_valid(sk_out_valid), .out_ready(out_ready | sel_ns), .out_data(sk_out_data),
        .occupancy(sk_occ), .cnt_clr(cnt_clr), .bubble_cnt(sk_cnt)
    );

    pipe_stage_skid #(.PAYLOAD_W(PW), .SKID_EN(0), .STALL_W(SW), .STALL_BIT(SB), .CNT_W(16)) u_noskid (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid & sel_ns), .in_ready(ns_in_ready), .in_data(in_data),
        .out_valid(ns_out_valid), .out_ready(out_ready | ~sel_ns), .out_data(ns_out_data),
        .occupancy(ns_occ), .cnt_clr(cnt_clr), .bubble_cnt(ns_cnt)
    );

    assign o_in_ready  = sel_ns ? ns_in_ready  : sk_in_ready;
    assign o_out_valid = sel_ns ? ns_out_valid : sk_out_valid;
    assign o_out_data  = sel_ns ? ns_out_data  : sk_out_data;
    assign o_occ       = sel_ns ? ns_occ       : sk_occ;
    assign o_cnt       = sel_ns ? ns_cnt       : {12'd0, sk_cnt};

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s (skid_mode=%0d): got %h expected %h", tag, !sel_ns, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // scoreboard: push accepted beats, pop on downstream transfer, flush empties it
    logic          mon_fire;
    logic [PW-1:0] mon_exp;
    always @(negedge clk) begin
        if (mon_en) begin
            mon_fire = o_out_valid & out_ready & ~stall[SB];
            check("mon_occupancy", PW'(o_occ), PW'(exp_q.size()));
            if (sel_ns)
                check("mon_in_ready", PW'(o_in_ready), PW'((exp_q.size() == 0) || mon_fire));
            else
                check("mon_in_ready", PW'(o_in_ready), PW'(exp_q.size() < 2));
            if (!o_out_valid) check("mon_bubble", o_out_data, BUB);
            if (flush) begin
                exp_q.delete();
            end else begin
                if (mon_fire) begin
                    if (exp_q.size() == 0) begin
                        check("mon_unexpected", PW'(o_out_valid), PW'(0));
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("mon_data", o_out_data, mon_exp);
                    end
                end
                if (in_valid && o_in_ready) exp_q.push_back(in_data);
            end
        end
    end

    task automatic wait_ready;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (o_in_ready) break;
            if (n == 19) check("ready_timeout", PW'(o_in_ready), PW'(1));
            tick();
        end
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; out_ready = 1'b1; stall = '0; flush = 1'b0;
        repeat (n) tick();
    endtask

    task automatic t_stream;
        out_ready = 1'b1;
        wait_ready();
        in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_data = PW'(k);
            @(negedge clk);
            check("t2_in_ready", PW'(o_in_ready), PW'(1));
            if (k > 1) begin
                check("t2_out_data", o_out_data, PW'(k - 1));
                check("t2_occupancy", PW'(o_occ), PW'(1));
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("t2_last_valid", PW'(o_out_valid), PW'(1));
        check("t2_last_data", o_out_data, PW'(8));
        tick();
        @(negedge clk);
        check("t2_drained", PW'(o_out_valid), PW'(0));
        tick();
    endtask

    task automatic t_backpressure;
        out_ready = 1'b0; in_valid = 1'b1; in_data = PW'('hA);
        @(negedge clk);
        check("t3_ready_a", PW'(o_in_ready), PW'(1));
        tick();
        in_data = PW'('hB);
        if (!sel_ns) begin
            @(negedge clk);
            check("t3_ready_b", PW'(o_in_ready), PW'(1));
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            check("t3_occ2", PW'(o_occ), PW'(2));
            check("t3_full_ready", PW'(o_in_ready), PW'(0));
            check("t3_hold_a", o_out_data, PW'('hA));
            tick();
            out_ready = 1'b1;
            @(negedge clk);
            check("t3_out_a", o_out_data, PW'('hA));
            tick();
            @(negedge clk);
            check("t3_out_b", o_out_data, PW'('hB));
            check("t3_occ1", PW'(o_occ), PW'(1));
            tick();
        end else begin
            @(negedge clk);
            check("t3_ns_blocked", PW'(o_in_ready), PW'(0));
            check("t3_ns_occ1", PW'(o_occ), PW'(1));
            tick();
            out_ready = 1'b1;
            @(negedge clk);
            check("t3_ns_pass_ready", PW'(o_in_ready), PW'(1));
            check("t3_ns_out_a", o_out_data, PW'('hA));
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            check("t3_ns_out_b", o_out_data, PW'('hB));
            tick();
        end
        @(negedge clk);
        check("t3_drained", PW'(o_out_valid), PW'(0));
        tick();
    endtask

    task automatic t_stall;
        out_ready = 1'b0; in_valid = 1'b1; in_data = PW'('hC0);
        tick();
        in_valid = 1'b0; out_ready = 1'b1; stall = 6'b000100;
        repeat (3) begin
            @(negedge clk);
            check("t4_stall_valid", PW'(o_out_valid), PW'(1));
            check("t4_stall_data", o_out_data, PW'('hC0));
            check("t4_stall_ready", PW'(o_in_ready), PW'(!sel_ns));
            tick();
        end
        stall = 6'b000010;
        @(negedge clk);
        check("t4_other_bit", o_out_data, PW'('hC0));
        tick();
        @(negedge clk);
        check("t4_released", PW'(o_out_valid), PW'(0));
        stall = '0;
        tick();
    endtask

    task automatic t_flush;
        // main empty: the same-cycle accepted beat must be dropped
        out_ready = 1'b0; in_valid = 1'b1; in_data = PW'('hE1); flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("t5_drop_valid", PW'(o_out_valid), PW'(0));
        check("t5_drop_occ", PW'(o_occ), PW'(0));
        tick();
        if (!sel_ns) begin
            in_valid = 1'b1; in_data = PW'('hD0);
            tick();
            in_data = PW'('hD1);
            tick();
            in_data = PW'('hD2); flush = 1'b1;
            @(negedge clk);
            check("t5_pre_occ", PW'(o_occ), PW'(2));
            tick();
            flush = 1'b0; in_valid = 1'b0;
            @(negedge clk);
            check("t5_valid", PW'(o_out_valid), PW'(0));
            check("t5_data", o_out_data, BUB);
            check("t5_occ", PW'(o_occ), PW'(0));
            tick();
        end
        idle(3);
    endtask

    task automatic t_counter;
        idle(20);
        @(negedge clk);
        check("t6_saturate", PW'(o_cnt), PW'(15));
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        @(negedge clk);
        check("t6_clear", PW'(o_cnt), PW'(0));
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("t6_count1", PW'(o_cnt), PW'(1));
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("t6_flush_keeps", PW'(o_cnt), PW'(2));
        tick();
        out_ready = 1'b0; in_valid = 1'b1; in_data = PW'('hF0);
        @(negedge clk);
        check("t6_count3", PW'(o_cnt), PW'(3));
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_last_inc", PW'(o_cnt), PW'(4));
        tick();
        @(negedge clk);
        check("t6_hold_full", PW'(o_cnt), PW'(4));
        tick();
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("t6_after_drain", PW'(o_cnt), PW'(4));
        tick();
    endtask

    task automatic t_random(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = PW'({$urandom, $urandom, $urandom, $urandom, $urandom});
            out_ready = ($urandom_range(0, 3) != 0);
            stall     = SW'($urandom_range(0, 63));
            flush     = ($urandom_range(0, 39) == 0);
            if (flush) out_ready = 1'b0;
            tick();
        end
        idle(5);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; cnt_clr = 1'b0; sel_ns = 1'b0;
        in_valid = 1'b1; in_data = PW'('h55); out_ready = 1'b1; stall = '0;
        repeat (2) tick();
        @(negedge clk);
        check("t1_out_valid", PW'(o_out_valid), PW'(0));
        check("t1_out_data", o_out_data, PW'(0));
        check("t1_in_ready", PW'(o_in_ready), PW'(0));
        check("t1_occupancy", PW'(o_occ), PW'(0));
        check("t1_bubble_cnt", PW'(o_cnt), PW'(0));
        check("t1_ns_in_ready", PW'(ns_in_ready), PW'(0));
        check("t1_ns_out_valid", PW'(ns_out_valid), PW'(0));
        tick();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        tick();
        mon_en = 1'b1;

        t_stream();
        t_backpressure();
        t_stall();
        t_flush();
        t_counter();
        t_random(400);

        idle(3);
        sel_ns = 1'b1;
        tick();
        t_stream();
        t_backpressure();
        t_stall();
        t_flush();
        t_random(400);

        idle(5);
        check("sb_left", PW'(exp_q.size()), PW'(0));
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
